spi_master: RTL

- SPI mode-0 initiator that drives an external or on-die SPI target (peripheral) from a parallel valid/ready interface.
- Serialises one DATA_W-bit word per chip-select frame, MSB first, and captures the target's MISO word at the same time.
- Sits in the chip core next to the SPI target logic.
- Used both to exercise that target over internal nets and to configure off-chip SPI devices through the digital pads.

---
 rtl/spi_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one DATA_W-bit MSB-first frame per chip-select, full duplex.
// Define SPI_MASTER_LOOPBACK_EN to add loopback_i, which feeds mosi back into the RX shifter.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback_i,
`endif
  output logic              cs_n_o
);

  // state | meaning
  // IDLE  | waiting for tx_valid, cs_n high
  // SETUP | cs_n low, sclk low for CLK_DIV cycles before the first rise
  // XFER  | sclk toggling, then one trailing low half-period before cs_n rises
  // GAP   | cs_n high; together with the IDLE cycle gives CS_GAP cycles between frames
  typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_e;

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  state_e state_q, state_d;

  logic [DW-1:0]     div_q, div_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;

  logic accept, div_tc, last_edge, gap_done, rx_bit;

  assign accept    = tx_valid_i && (state_q == IDLE);
  assign div_tc    = (int'(div_q) == CLK_DIV - 1);
  assign last_edge = (int'(edge_q) == 2 * DATA_W);
  assign gap_done  = (int'(gap_q) + 2 >= CS_GAP);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback_i ? tx_sr_q[DATA_W-1] : miso_i;
`else
  assign rx_bit = miso_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (div_tc) state_d = XFER;
      XFER:    if (div_tc && last_edge) state_d = (CS_GAP > 1) ? GAP : IDLE;
      GAP:     if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d      = div_q;
    edge_d     = edge_q;
    gap_d      = gap_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_sr_d = tx_data_i;
          rx_sr_d = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          edge_d  = '0;
          gap_d   = '0;
        end
      end
      SETUP: begin
        if (div_tc) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          edge_d  = EW'(1);
          rx_sr_d = {rx_sr_q[DATA_W-2:0], rx_bit};
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      XFER: begin
        if (!div_tc) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          if (last_edge) begin
            cs_n_d     = 1'b1;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            busy_d     = (CS_GAP > 1) ? 1'b1 : 1'b0;
          end else begin
            sclk_d = !sclk_q;
            edge_d = edge_q + EW'(1);
            if (!sclk_q) begin
              rx_sr_d = {rx_sr_q[DATA_W-2:0], rx_bit};
            end else if (int'(edge_q) + 1 < 2 * DATA_W) begin
              tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      GAP: begin
        if (gap_done) busy_d = 1'b0;
        else          gap_d  = gap_q + GW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q      <= '0;
      edge_q     <= '0;
      gap_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      div_q      <= div_d;
      edge_q     <= edge_d;
      gap_q      <= gap_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign tx_ready_o = (state_q == IDLE);
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = tx_sr_q[DATA_W-1];
  assign cs_n_o     = cs_n_q;

endmodule
